// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multi-cycle RV32I datapath: fetch/decode/execute/memory/writeback
// with ready-stretched memory states and a trap on illegal opcodes or bus timeout.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] imm_src_o,
  output logic       instr_done_o,
  output logic       trap_o,
  output logic       bus_timeout_o
);

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
    StExecR, StExecI, StAluWb, StBeq, StJal, StTrap
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_timeout_q, bus_timeout_d;
  logic             stall, timeout_hit;

  assign stall       = (state_q inside {StFetch, StMemRead, StMemWrite}) && !mem_ready_i;
  assign timeout_hit = stall && (TIMEOUT != 0) && (cnt_q == TimeoutCnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus_timeout_d = bus_timeout_q;
    case (state_q)
      StIdle:     state_d = StFetch;
      StFetch:    if (mem_ready_i) state_d = StDecode;
      StDecode: begin
        case (opcode_i)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      // Loads and stores differ only in opcode bit 5.
      StMemAdr:   state_d = opcode_i[5] ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready_i) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready_i) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      StTrap:     state_d = StTrap;
      default:    state_d = StTrap;
    endcase
    if (timeout_hit) begin
      state_d       = StTrap;
      bus_timeout_d = 1'b1;
    end
    cnt_d = (state_d != state_q) ? '0 : (stall ? cnt_q + 1'b1 : cnt_q);
  end

  always_comb begin
    mem_req_o     = 1'b0;
    adr_src_o     = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    result_src_o  = 2'b00;
    alu_src_a_o   = 2'b00;
    alu_src_b_o   = 2'b00;
    alu_op_o      = 2'b00;
    imm_src_o     = 2'b00;
    instr_done_o  = 1'b0;
    trap_o        = 1'b0;
    bus_timeout_o = bus_timeout_q;
    case (state_q)
      StFetch: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      StDecode: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        imm_src_o   = 2'b10;
      end
      StMemAdr: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        imm_src_o   = opcode_i[5] ? 2'b01 : 2'b00;
      end
      StMemRead: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
      end
      StMemWb: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      StMemWrite: begin
        mem_req_o    = 1'b1;
        mem_write_o  = 1'b1;
        adr_src_o    = 1'b1;
        instr_done_o = mem_ready_i;
      end
      StExecR: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
      end
      StExecI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
      end
      StAluWb: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      StBeq: begin
        alu_src_a_o  = 2'b10;
        alu_op_o     = 2'b01;
        pc_write_o   = zero_i;
        instr_done_o = 1'b1;
      end
      StJal: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        imm_src_o   = 2'b11;
        pc_write_o  = 1'b1;
      end
      StTrap:  trap_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle vector table, randomized instruction
// stream against a phase-level latency/strobe model, and directed reset/trap/timeout sequences.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic       clk, rst_n;
  logic [6:0] opcode;
  logic       zero, mem_ready;
  logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic       instr_done, trap, bus_timeout;
  logic [18:0] outs;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req), .adr_src_o(adr_src), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .pc_write_o(pc_write), .reg_write_o(reg_write), .result_src_o(result_src),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .imm_src_o(imm_src),
    .instr_done_o(instr_done), .trap_o(trap), .bus_timeout_o(bus_timeout)
  );

  assign outs = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, result_src,
                 alu_src_a, alu_src_b, alu_op, imm_src, instr_done, trap, bus_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] ev(input logic [5:0] strb, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op, input logic [1:0] imm,
                                     input logic [2:0] tail);
    return {strb, rs, a, b, op, imm, tail};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic [6:0] op, input logic z, input logic rdy);
    @(negedge clk);
    opcode = op;
    zero = z;
    mem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_outs", 32'(outs), 32'd0);
  endtask

  // Phase model: fetch waits wf cycles, data access waits wm cycles, fixed stages otherwise.
  task automatic run_instr(input logic [6:0] op, input logic z, input int wf, input int wm,
                           output int obs_len);
    int lat, ms, exp_rw, exp_rwd, exp_pw, exp_wr;
    int rw, rwd, pw, wr, done_cnt, trp;
    logic rdy;
    lat = wf + 1; ms = -1;
    exp_rw = 0; exp_rwd = 0; exp_pw = 1; exp_wr = 0;
    rw = 0; rwd = 0; pw = 0; wr = 0; done_cnt = 0; trp = 0; obs_len = 0;
    case (op)
      OP_LD:  begin ms = lat + 2; lat += 2 + wm + 1 + 1; exp_rw = 1; exp_rwd = 1; end
      OP_ST:  begin ms = lat + 2; lat += 2 + wm + 1; exp_wr = 1; end
      OP_BEQ: begin lat += 2; exp_pw += int'(z); end
      OP_JAL: begin lat += 3; exp_rw = 1; exp_pw += 1; end
      default: begin lat += 3; exp_rw = 1; end
    endcase
    for (int k = 0; k < lat; k++) begin
      if (k < wf) rdy = 1'b0;
      else if (k == wf) rdy = 1'b1;
      else if (ms >= 0 && k >= ms && k < ms + wm) rdy = 1'b0;
      else if (ms >= 0 && k == ms + wm) rdy = 1'b1;
      else rdy = 1'($urandom % 2);
      step(op, z, rdy);
      rw += int'(reg_write);
      rwd += int'(reg_write && result_src == 2'b01);
      pw += int'(pc_write);
      wr += int'(mem_req && mem_write && mem_ready);
      done_cnt += int'(instr_done);
      trp += int'(trap);
      if (instr_done && obs_len == 0) obs_len = k + 1;
    end
    chk("latency", 32'(obs_len), 32'(lat));
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("reg_write_count", 32'(rw), 32'(exp_rw));
    chk("reg_write_data_count", 32'(rwd), 32'(exp_rwd));
    chk("pc_write_count", 32'(pw), 32'(exp_pw));
    chk("store_count", 32'(wr), 32'(exp_wr));
    chk("no_trap", 32'(trp), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [6:0] op, input logic z, input logic [18:0] e);
    vec_t v;
    v.name = n; v.op = op; v.z = z; v.rdy = 1'b1; v.exp = e;
    vecs.push_back(v);
  endtask

  logic [18:0] v_f, v_fs, v_d, v_xr, v_xi, v_wb, v_mal, v_mas, v_mr, v_mwb, v_mw, v_mws;
  logic [18:0] v_bq1, v_bq0, v_j, v_trap, v_to;
  logic [6:0]  ops [6];
  int          len;

  initial begin
    rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    ops = '{OP_LD, OP_ST, OP_R, OP_I, OP_BEQ, OP_JAL};

    v_f    = ev(6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000);
    v_fs   = ev(6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000);
    v_d    = ev(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000);
    v_xr   = ev(6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    v_xi   = ev(6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 3'b000);
    v_wb   = ev(6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100);
    v_mal  = ev(6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000);
    v_mas  = ev(6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000);
    v_mr   = ev(6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    v_mwb  = ev(6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100);
    v_mw   = ev(6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100);
    v_mws  = ev(6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    v_bq1  = ev(6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 3'b100);
    v_bq0  = ev(6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 3'b100);
    v_j    = ev(6'b000010, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 3'b000);
    v_trap = ev(6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010);
    v_to   = ev(6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b011);

    add("r_fetch", OP_R, 1, v_f);   add("r_decode", OP_R, 1, v_d);
    add("r_exec", OP_R, 1, v_xr);   add("r_wb", OP_R, 1, v_wb);
    add("i_fetch", OP_I, 0, v_f);   add("i_decode", OP_I, 0, v_d);
    add("i_exec", OP_I, 0, v_xi);   add("i_wb", OP_I, 0, v_wb);
    add("lw_fetch", OP_LD, 0, v_f); add("lw_decode", OP_LD, 0, v_d);
    add("lw_adr", OP_LD, 0, v_mal); add("lw_read", OP_LD, 0, v_mr);
    add("lw_wb", OP_LD, 0, v_mwb);
    add("sw_fetch", OP_ST, 0, v_f); add("sw_decode", OP_ST, 0, v_d);
    add("sw_adr", OP_ST, 0, v_mas); add("sw_write", OP_ST, 0, v_mw);
    add("beq_fetch", OP_BEQ, 1, v_f); add("beq_decode", OP_BEQ, 1, v_d);
    add("beq_taken", OP_BEQ, 1, v_bq1);
    add("jal_fetch", OP_JAL, 0, v_f); add("jal_decode", OP_JAL, 0, v_d);
    add("jal_jump", OP_JAL, 0, v_j);  add("jal_wb", OP_JAL, 0, v_wb);

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].z, vecs[i].rdy);
      chk(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
    end

    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 5)], 1'($urandom % 2), $urandom_range(0, 2),
                $urandom_range(0, 2), len);

    run_instr(OP_LD, 1'b0, 0, 3, len);
    chk("lw_wait3_len", 32'(len), 32'd8);
    run_instr(OP_BEQ, 1'b0, 0, 0, len);
    chk("beq_not_taken_len", 32'(len), 32'd3);
    run_instr(OP_BEQ, 1'b1, 0, 0, len);
    chk("beq_taken_len", 32'(len), 32'd3);
    run_instr(OP_JAL, 1'b0, 0, 0, len);
    chk("jal_len", 32'(len), 32'd4);
    step(OP_BEQ, 1'b0, 1'b1); step(OP_BEQ, 1'b0, 1'b1); step(OP_BEQ, 1'b0, 1'b1);
    chk("beq_not_taken_outs", 32'(outs), 32'(v_bq0));

    // Async reset while a store is stalled.
    do_reset();
    step(OP_ST, 0, 1); step(OP_ST, 0, 0); step(OP_ST, 0, 0); step(OP_ST, 0, 0);
    chk("memwrite_stall", 32'(outs), 32'(v_mws));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_drop", 32'(outs), 32'd0);
    do_reset();
    step(OP_R, 0, 1);
    chk("fetch_after_reset", 32'(outs), 32'(v_f));

    // Ready arriving on the exact timeout cycle completes normally.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(OP_R, 0, 0);
      chk("fetch_stall", 32'(outs), 32'(v_fs));
    end
    step(OP_R, 0, 1);
    chk("fetch_ready_at_limit", 32'(outs), 32'(v_f));
    step(OP_R, 0, 1);
    chk("decode_after_limit", 32'(outs), 32'(v_d));

    // Bus timeout in fetch.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step(OP_R, 0, 0);
      chk("fetch_stall_to", 32'(outs), 32'(v_fs));
    end
    for (int k = 0; k < 4; k++) begin
      step(OP_R, 1'($urandom % 2), 1'($urandom % 2));
      chk("timeout_trap", 32'(outs), 32'(v_to));
    end

    // Illegal opcode.
    do_reset();
    step(7'b1111111, 0, 1);
    chk("illegal_fetch", 32'(outs), 32'(v_f));
    step(7'b1111111, 0, 1);
    chk("illegal_decode", 32'(outs), 32'(v_d));
    for (int k = 0; k < 4; k++) begin
      step(7'b1111111, 1'($urandom % 2), 1'($urandom % 2));
      chk("illegal_trap", 32'(outs), 32'(v_trap));
    end
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style sequencing FSM for the multi-cycle RV32I datapath: one shared memory port, instruction register (IR), old-PC/A/B/ALUOut/Data registers.
- Decodes opcode from the IR and steps the datapath through fetch, decode, execute, memory and writeback, one state per cycle.
- Stretches memory states with a ready handshake and traps on illegal opcodes or bus timeout.
- Sits beside the existing ALU decoder, which consumes alu_op.

Parameters:
TIMEOUT, 16, max stall cycles in a memory state before trapping; 0 disables the timeout.
CNT_W, 8, timeout counter width; must satisfy TIMEOUT < 2**CNT_W.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0]; stable from DECODE until the next fetch
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
adr_src  out  1  0 = PC, 1 = ALUOut as address
mem_write  out  1  write qualifier for the current request
ir_write  out  1  load IR and old-PC
pc_write  out  1  load PC
reg_write  out  1  register file write enable
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  out  2  00 PC, 01 old-PC, 10 A
alu_src_b  out  2  00 B, 01 ImmExt, 10 constant 4
alu_op  out  2  00 add, 01 subtract/branch, 10 funct-decoded
imm_src  out  2  00 I, 01 S, 10 B, 11 J
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
trap  out  1  halted: illegal opcode or bus timeout
bus_timeout  out  1  trap cause is timeout; sticky until reset

Behaviour:
Reset:
- rst_n low asynchronously forces state IDLE, clears the counter, trap and bus_timeout.
- Every output is 0 while in IDLE.
- IDLE moves to FETCH on the first clock after rst_n deasserts.
- Reset mid-instruction abandons it with no write strobes emitted.

Output rules:
- Outputs are decoded from state only, except that pc_write and ir_write in FETCH follow mem_ready, and pc_write in BEQ follows zero.
- Any output not listed for a state is 0; outputs never carry X.

States and transitions:
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - When mem_ready: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE.
  - Otherwise hold.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other value -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; imm_src=00 for loads, 01 for stores. Next is MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_req=1, adr_src=1. Goes to MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next is FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. On mem_ready: instr_done=1, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next is ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, imm_src=00, alu_op=10. Next is ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next is FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero, instr_done=1. Next is FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, imm_src=11, pc_write=1 (PC <- ALUOut target). Next is ALUWB (rd <- PC+4).
- TRAP: trap=1, all enables 0. Terminal until reset.

Latency with zero-wait memory:
- lw: 5 cycles
- R-type, I-type, sw, jal: 4 cycles
- beq: 3 cycles
- Each wait cycle adds exactly one cycle.

Timeout:
- The counter increments each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
- It clears on any state change.
- When the counter equals TIMEOUT with mem_ready still 0 and TIMEOUT != 0: go to TRAP and set bus_timeout.
- No write strobe is issued in that cycle.
- mem_ready=1 on the cycle the counter equals TIMEOUT completes normally.

Test Plan:
- Reset mid-MEMWRITE with mem_ready=0 -> outputs drop to 0 asynchronously; after release, IDLE then FETCH; no mem_write pulse ever coincides with mem_ready.
- R-type (opcode 0110011), mem_ready tied 1 -> states FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in cycle 4, instr_done on cycle 4; then alu_op=10 in EXECR.
- lw with mem_ready low 3 cycles in MEMREAD -> 8 cycles total; reg_write with result_src=01 exactly once.
- beq with zero=1, then again with zero=0 -> pc_write pulses in BEQ only in the zero=1 case; 3 cycles each.
- jal (1101111) -> pc_write=1 in JAL, then ALUWB with reg_write=1; 4 cycles total.
- Opcode 1111111, then separately mem_ready held 0 in FETCH with TIMEOUT=16 -> first case: trap=1 after DECODE with bus_timeout=0; second case: trap=1 and bus_timeout=1 after 16 stall cycles; both held until rst_n.
